// File: rtl/control_pipeline_param.sv
// control_pipeline_param: DEPTH-stage valid/tag delay line with stall, flush, frame counting and sticky drop error
module control_pipeline_param #(
  parameter int DEPTH   = 2,
  parameter int TAG_W   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in_bias,
  input  logic [TAG_W-1:0]   tag_in,
  input  logic               stall,
  input  logic               flush,
  input  logic [COUNT_W-1:0] frame_len,
  output logic [DEPTH-1:0]   valid_pipeline,
  output logic               valid_out,
  output logic [TAG_W-1:0]   tag_out,
  output logic [COUNT_W-1:0] out_count,
  output logic               frame_done,
  output logic               busy,
  output logic               drop_err
);
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic last;
  assign last = (frame_len != '0) && (out_count == frame_len - COUNT_W'(1));
  assign busy = (|valid_pipeline) | valid_out;
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_pipeline <= '0;
      valid_out      <= 1'b0;
      tag_out        <= '0;
      out_count      <= '0;
      frame_done     <= 1'b0;
      drop_err       <= 1'b0;
      for (int k = 0; k < DEPTH; k++) tag_q[k] <= '0;
    end else if (flush) begin
      valid_pipeline <= '0;
      valid_out      <= 1'b0;
      out_count      <= '0;
      frame_done     <= 1'b0;
    end else if (stall) begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      drop_err   <= drop_err | valid_in_bias;
    end else begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        valid_pipeline[k] <= valid_pipeline[k-1];
        tag_q[k]          <= tag_q[k-1];
      end
      valid_pipeline[0] <= valid_in_bias;
      tag_q[0]          <= tag_in;
      valid_out         <= valid_pipeline[DEPTH-1];
      tag_out           <= tag_q[DEPTH-1];
      frame_done        <= valid_pipeline[DEPTH-1] & last;
      if (valid_pipeline[DEPTH-1]) out_count <= last ? '0 : out_count + COUNT_W'(1);
    end
  end
endmodule
